// File: rtl/inst_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// inst_fetch_arbiter
// Shares a single-ported combinational instruction ROM between the pipeline
// fetch stage (IF) and a debug/loader read port (DBG). One ROM access is
// granted per cycle. Grants are combinational and read data is registered,
// so the data for a grant in cycle N appears in cycle N+1.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      IF fetch request and byte address
//   if_gnt              IF request accepted this cycle (combinational)
//   if_rvalid/if_rdata  registered instruction for last cycle's IF grant
//   dbg_req/dbg_lock    debug read request and bus-ownership lock
//   dbg_addr            debug byte address
//   dbg_gnt             debug request accepted this cycle (combinational)
//   dbg_rvalid/rdata    registered data for last cycle's DBG grant
//   rom_ce/rom_addr     ROM chip-enable and address (0 when idle)
//   rom_inst            combinational ROM read data
//   stallreq            IF requested but was not granted
//
// Configuration macro: INST_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, IF always wins, dbg_lock ignored
//   undefined -> round-robin arbitration with debug lock
// ---------------------------------------------------------------------------
module inst_fetch_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dbg_req,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IF_OWN     = 2'd1,
        DBG_OWN    = 2'd2,
        DBG_LOCKED = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_if_gnt;
    logic              w_dbg_gnt;
    logic              r_if_rvalid;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decision and next state
    always_comb begin
        w_if_gnt    = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_state_nxt = IDLE;
`ifdef INST_ARB_FIXED_PRIO_EN
        if (if_req) begin
            w_if_gnt = 1'b1;
        end else if (dbg_req) begin
            w_dbg_gnt = 1'b1;
        end
        if (w_if_gnt) begin
            w_state_nxt = IF_OWN;
        end else if (w_dbg_gnt) begin
            w_state_nxt = DBG_OWN;
        end
`else
        if (if_req && !dbg_req) begin
            w_if_gnt = 1'b1;
        end else if (dbg_req && !if_req) begin
            w_dbg_gnt = 1'b1;
        end else if (if_req && dbg_req) begin
            // Contention: lock keeps DBG; otherwise favour the port not served last
            case (r_state)
                IF_OWN, DBG_LOCKED: w_dbg_gnt = 1'b1;
                default:            w_if_gnt  = 1'b1;
            endcase
        end
        if (w_if_gnt) begin
            w_state_nxt = IF_OWN;
        end else if (w_dbg_gnt) begin
            w_state_nxt = dbg_lock ? DBG_LOCKED : DBG_OWN;
        end
`endif
    end

    // Read-return registers; a non-granted port keeps its last data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rvalid  <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_if_rvalid  <= w_if_gnt;
            r_dbg_rvalid <= w_dbg_gnt;
            if (w_if_gnt) begin
                r_if_rdata <= rom_inst;
            end
            if (w_dbg_gnt) begin
                r_dbg_rdata <= rom_inst;
            end
        end
    end

    assign if_gnt     = w_if_gnt;
    assign dbg_gnt    = w_dbg_gnt;
    assign rom_ce     = w_if_gnt | w_dbg_gnt;
    assign rom_addr   = w_if_gnt  ? if_addr  :
                        w_dbg_gnt ? dbg_addr : '0;
    assign stallreq   = if_req & ~w_if_gnt;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Self-checking bench for inst_fetch_arbiter: behavioural arbitration model,
// per-cycle comparison on the falling edge, directed literal checks, random run.
module tb_inst_fetch_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef INST_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dbg_req;
    logic          dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst;
    logic          stallreq;

    int n_pass  = 0;
    int n_total = 0;

    inst_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dbg_req   (dbg_req),
        .dbg_lock  (dbg_lock),
        .dbg_addr  (dbg_addr),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_inst  (rom_inst),
        .stallreq  (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word index offset from a base, low address bits ignored
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return 32'h3401_1100 + {2'b00, a[AW-1:2]};
    endfunction
    assign rom_inst = rom_fn(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: who was served last (0 none, 1 IF, 2 DBG) and whether DBG holds a lock
    int            m_last;
    bit            m_locked;
    logic          m_if_rvalid, m_dbg_rvalid;
    logic [DW-1:0] m_if_rdata, m_dbg_rdata;

    function automatic int pick(input logic ir, input logic dr, input int last, input bit locked);
        if (ir && dr && !FIXED) begin
            if (locked) return 2;
            return (last == 1) ? 2 : 1;
        end
        if (ir) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = 0; m_locked = 1'b0;
            m_if_rvalid = 1'b0; m_dbg_rvalid = 1'b0;
            m_if_rdata = '0; m_dbg_rdata = '0;
        end else begin
            int g;
            g = pick(if_req, dbg_req, m_last, m_locked);
            m_if_rvalid  = (g == 1);
            m_dbg_rvalid = (g == 2);
            if (g == 1) m_if_rdata  = rom_fn(if_addr);
            if (g == 2) m_dbg_rdata = rom_fn(dbg_addr);
            m_last   = g;
            m_locked = (g == 2) && dbg_lock && !FIXED;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int g;
        logic [AW-1:0] ea;
        g  = pick(if_req, dbg_req, m_last, m_locked);
        ea = (g == 1) ? if_addr : (g == 2) ? dbg_addr : '0;
        chk("if_gnt",     32'(if_gnt),     32'(g == 1));
        chk("dbg_gnt",    32'(dbg_gnt),    32'(g == 2));
        chk("rom_ce",     32'(rom_ce),     32'(g != 0));
        chk("rom_addr",   rom_addr,        ea);
        chk("stallreq",   32'(stallreq),   32'(if_req && g != 1));
        chk("if_rvalid",  32'(if_rvalid),  32'(m_if_rvalid));
        chk("if_rdata",   if_rdata,        m_if_rdata);
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_dbg_rvalid));
        chk("dbg_rdata",  dbg_rdata,       m_dbg_rdata);
    end

    task automatic step(input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dl, input logic [AW-1:0] da);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_lock = dl; dbg_addr = da;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; dbg_req = 1'b0; dbg_lock = 1'b0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_rvalid",  32'(if_rvalid),  32'd0);
        chk("rst_if_rdata",   if_rdata,        32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_rom_ce",     32'(rom_ce),     32'd0);

        // IF-only stream
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h0;
        @(negedge clk);
        chk("lit_if_gnt0", 32'(if_gnt), 32'd1);
        chk("lit_stall0",  32'(stallreq), 32'd0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lit_if_rdata0", if_rdata, 32'h3401_1100);
        chk("lit_rom_addr4", rom_addr, 32'h4);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lit_if_rdata1", if_rdata, 32'h3401_1101);

        // Idle
        step(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lit_if_rdata2", if_rdata, 32'h3401_1102);
        chk("lit_idle_ce",   32'(rom_ce), 32'd0);
        chk("lit_idle_addr", rom_addr, 32'h0);

        // Contention from IDLE: IF, DBG, IF, DBG
        step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            if (k == 0) begin
                chk("lit_idle_rvalid", 32'(if_rvalid), 32'd0);
                chk("lit_idle_hold",   if_rdata, 32'h3401_1102);
            end
            chk("lit_cont_if_gnt", 32'(if_gnt), 32'(FIXED || (k % 2 == 0)));
            chk("lit_cont_addr", rom_addr, (FIXED || (k % 2 == 0)) ? 32'h10 : 32'h20);
        end

        // Lock: DBG alone takes the lock, then holds it against IF
        step(1'b0, 32'h10, 1'b1, 1'b1, 32'h24);
        @(negedge clk);
        chk("lit_lock_first", 32'(dbg_gnt), 32'd1);
        step(1'b1, 32'h10, 1'b1, 1'b1, 32'h28);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("lit_lock_dbg_gnt", 32'(dbg_gnt),  32'(!FIXED));
            chk("lit_lock_stall",   32'(stallreq), 32'(!FIXED));
        end
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h28);
        @(negedge clk);
        chk("lit_unlock_if", 32'(if_gnt), 32'd1);

        // Async reset with an IF read in flight
        step(1'b0, 32'h8, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("lit_pre_rst_rvalid", 32'(if_rvalid), 32'd1);
        chk("lit_pre_rst_rdata",  if_rdata, 32'h3401_1102);
        #2 rst = 1'b1;
        #1;
        chk("lit_async_rvalid", 32'(if_rvalid), 32'd0);
        chk("lit_async_rdata",  if_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Random traffic with occasional mid-cycle resets
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
